fpmul_arb: RTL and testbench
============================

# fpmul_arb

Shared-resource arbiter and sequencer for the single-precision multiplier `fpmul`. It accepts multiply requests from `NREQ` independent requesters over valid/ready handshakes and grants one per cycle in round-robin order. It drives the combinational `fpmul` with the granted operands and captures the product in a one-entry output register, returned with the requester ID. It sits between the LVG-32 execution/pipeline clients and the FP datapath, so only one multiplier instance is needed.

## Interface

**Parameters**
- `NREQ`, default 2: number of requesters, range 2..8.
- `IDW`, default 1: response ID width, equal to clog2(`NREQ`), minimum 1.

**Ports** (clock and reset first)
- `clk` input, 1: sole clock, rising edge.
- `rst_n` input, 1: reset, asynchronous assert, active-low.
- `req_valid` input, `NREQ`: per-requester request valid.
- `req_ready` output, `NREQ`: per-requester accept; one-hot or zero.
- `req_a` input, 32×`NREQ`: operand A, packed; requester i at bits [32i+31:32i].
- `req_b` input, 32×`NREQ`: operand B, packed the same way as `req_a`.
- `rsp_valid` output, 1: product available.
- `rsp_ready` input, 1: consumer accepts the product.
- `rsp_id` output, `IDW`: index of the requester that owns the product.
- `rsp_result` output, 32: IEEE-754 single product, as computed by `fpmul`.
- `busy` output, 1: output register occupied (equals `rsp_valid`).

## Operation

- Output register states:
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- `can_accept` = EMPTY or (FULL and `rsp_ready`).
- **Arbitration:** round-robin pointer `ptr` (`IDW` bits).
  - Grant goes to the first i with `req_valid[i]`, searching ptr, ptr+1, … mod `NREQ`.
  - `req_ready[i]` = `can_accept` and grant==i. A requester is never granted without `req_valid`.
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`. It never depends on the operand values.
- **Accept** (`req_valid[g]` and `req_ready[g]`):
  - `fpmul` is fed `req_a[g]`, `req_b[g]` combinationally.
  - Its result is registered into `rsp_result`, and g into `rsp_id`; state becomes FULL.
  - `ptr` becomes (g+1) mod `NREQ`.
- **Transitions:**
  - FULL with `rsp_ready` and no accept → EMPTY.
  - FULL with `rsp_ready` and an accept → stays FULL with the new data (back-to-back).
  - FULL with no `rsp_ready` → hold `rsp_result` and `rsp_id` stable; all `req_ready`=0.
- **Idle:** with no `req_valid`, `ptr` is unchanged.
- **Arithmetic:** no rounding, flushing or special-case handling here. The result bits are exactly the `fpmul` output for the granted operands.
- **Reset** (`rst_n` low, any time, including mid-handshake):
  - Immediately `rsp_valid`=0, `busy`=0, `rsp_id`=0, `rsp_result`=32'h0, `ptr`=0.
  - `req_ready`=0 while reset is asserted.
  - An in-flight product is discarded; the requester must re-issue.
- **Requester obligation:** hold `req_valid`, `req_a` and `req_b` stable until accepted. The arbiter does not check this.

## Timing

- Latency: an accept in cycle N gives `rsp_valid`=1 at cycle N+1, with result and ID registered.
- Throughput: one product per cycle while `rsp_ready` is held high.
- Fairness: a continuously valid requester is granted within `NREQ` accept cycles.
- The critical path is the arbiter mux, then `fpmul`, then the output register. It is single-cycle; no internal pipelining.
- First cycle after `rst_n` deasserts: grant eligibility starts at requester 0.

## Structure

- Shared package `lvg_fp_pkg`:
  - `FP_W`=32.
  - Constants for ±0, +1.0 (32'h3f800000) and ±inf, for benches.
  - A helper function for clog2.
- Sub-modules:
  - `fpmul` is instantiated once, unchanged.
  - The round-robin grant logic is a natural sub-module, `rr_arbiter`, parameterized by `NREQ`, with inputs `req`, `ptr` and outputs `gnt` one-hot, `gnt_idx`. It is reusable for future shared fpadd/fpdiv.

## Test plan

- **Reset:** `rst_n`=0 mid-transfer with `rsp_valid`=1 → outputs clear immediately. After release, requester 0 wins a simultaneous request.
- **Single request:** requester 0, a=3f115b57, b=3fab851f, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_result`=3f42c732, `rsp_id`=0.
- **Contention:** requesters 0 and 1 both valid continuously, ptr=0. Requester 0 carries a=3aa137f4, b=3c4985f0; requester 1 carries a=3f800000, b=3f800000. Required grant order: 0, 1, 0, 1. Required results: 377dd28f (id 0), 3f800000 (id 1), alternating.
- **Backpressure:** `rsp_ready`=0 for 3 cycles while FULL → `rsp_result`/`rsp_id` stable and all `req_ready`=0. `rsp_ready`=1 → drain and accept the pending request in the same cycle.
- **Zero operands:** a=00000000, b=3fab851f, then a=b=00000000 → results 00000000 on consecutive cycles, no bubble.
- **Idle:** no `req_valid` for 5 cycles → `ptr` unchanged. The next single request from requester 1 is granted in its first valid cycle.

Source files
------------

// File: rtl/lvg_fp_pkg.sv
// Shared FP package for the LVG-32 FP datapath.
//   FP_W        : IEEE-754 single word width
//   FP_*        : common encodings (signed zeros, +1.0, infinities, quiet NaN)
//   out_state_e : occupancy of a one-entry result register
//   clog2       : ceil(log2(n)), 0 for n <= 1
package lvg_fp_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [FP_W-1:0] FP_ONE      = 32'h3f80_0000;
  localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7f80_0000;
  localparam logic [FP_W-1:0] FP_NEG_INF  = 32'hff80_0000;
  localparam logic [FP_W-1:0] FP_QNAN     = 32'h7fc0_0000;

  typedef enum logic {StEmpty, StFull} out_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpmul_arb_if.sv
// Request/response bundle between LVG-32 clients and the shared multiplier.
//   req_valid/req_ready : per-requester handshake (NREQ bits)
//   req_a/req_b         : packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready : product handshake
//   rsp_id/rsp_result   : owner index and IEEE-754 single product
//   busy                : result register occupied
// master = client side, slave = arbiter side.
interface fpmul_arb_if import lvg_fp_pkg::*; #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) ();

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [FP_W*NREQ-1:0] req_a;
  logic [FP_W*NREQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [FP_W-1:0]      rsp_result;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

endinterface

// File: rtl/fpmul.sv
// Combinational IEEE-754 single-precision multiplier.
//   a, b : operands
//   p    : product
// Mantissa is truncated (round toward zero). Denormal inputs are treated as
// zero, underflow flushes to signed zero, overflow saturates to max finite
// (the round-toward-zero result). NaN in, or inf * 0, gives the quiet NaN.
module fpmul import lvg_fp_pkg::*; (
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] p
);

  logic        sp;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic        norm;
  logic [22:0] frac;
  logic [9:0]  esum;
  logic        unused_prod_lsbs;

  assign sp = a[31] ^ b[31];
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hff) && (fa == 23'h0);
  assign b_inf  = (eb == 8'hff) && (fb == 23'h0);
  assign a_nan  = (ea == 8'hff) && (fa != 23'h0);
  assign b_nan  = (eb == 8'hff) && (fb != 23'h0);

  assign prod = {1'b1, fa} * {1'b1, fb};
  // Product of two [1,2) mantissas lies in [1,4); bit 47 marks the [2,4) half.
  assign norm = prod[47];
  assign frac = norm ? prod[46:24] : prod[45:23];
  // Biased sum before removing one bias: result exponent is esum - 127.
  assign esum = {2'b00, ea} + {2'b00, eb} + {9'b0, norm};

  assign unused_prod_lsbs = ^prod[22:0];

  always_comb begin
    p = FP_POS_ZERO;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p = FP_QNAN;
    end else if (a_inf || b_inf) begin
      p = {sp, 8'hff, 23'h0};
    end else if (a_zero || b_zero || (esum <= 10'd127)) begin
      p = {sp, 31'h0};
    end else if (esum >= 10'd382) begin
      p = {sp, 8'hfe, 23'h7fffff};
    end else begin
      // esum - 127 modulo 256 equals esum[7:0] + 129.
      p = {sp, esum[7:0] + 8'd129, frac};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant.
//   req     : request vector (NREQ)
//   ptr     : highest-priority index this cycle (< NREQ)
//   gnt     : one-hot grant, zero when no request
//   gnt_idx : index of the granted requester (ptr when no request)
// Search order is ptr, ptr+1, ... modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [NREQ-1:0] rot;
  logic            found;
  logic [IDW:0]    off;
  logic [IDW:0]    sum;

  always_comb begin
    // Rotate so that bit 0 of rot is requester ptr.
    rot   = NREQ'({req, req} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        off   = (IDW+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDW+1)'(NREQ)) begin
      sum = sum - (IDW+1)'(NREQ);
    end
    gnt_idx = sum[IDW-1:0];
    gnt     = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = found && (sum == (IDW+1)'(i));
    end
  end

endmodule

// File: rtl/fpmul_arb.sv
// Round-robin arbiter in front of one shared fpmul with a one-entry result
// register.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fpmul_arb_if slave (requests in, product/ID out, busy)
// Accept in cycle N gives rsp_valid in N+1; one product per cycle when the
// consumer keeps rsp_ready high.
module fpmul_arb import lvg_fp_pkg::*; #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (clog2(NREQ) > 0) ? clog2(NREQ) : 1
) (
  input logic        clk,
  input logic        rst_n,
  fpmul_arb_if.slave bus
);

  out_state_e      st_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_nxt;
  logic [IDW-1:0]  rsp_id_q;
  logic [FP_W-1:0] rsp_result_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            can_accept;
  logic            accept;
  logic [FP_W-1:0] a_sel;
  logic [FP_W-1:0] b_sel;
  logic [FP_W-1:0] prod;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign can_accept = (st_q == StEmpty) || bus.rsp_ready;
  // rst_n gates ready so nothing is handed over while reset is held.
  assign bus.req_ready = (rst_n && can_accept) ? gnt : '0;
  assign accept        = |bus.req_ready;

  // AND-OR operand mux on the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = a_sel | bus.req_a[i*FP_W +: FP_W];
        b_sel = b_sel | bus.req_b[i*FP_W +: FP_W];
      end
    end
  end

  fpmul u_fpmul (
    .a (a_sel),
    .b (b_sel),
    .p (prod)
  );

  assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= StEmpty;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      unique case (st_q)
        StEmpty: begin
          if (accept) begin
            st_q <= StFull;
          end
        end
        StFull: begin
          // Drain and refill in the same cycle keeps the register FULL.
          if (!accept && bus.rsp_ready) begin
            st_q <= StEmpty;
          end
        end
        default: st_q <= StEmpty;
      endcase
      if (accept) begin
        rsp_result_q <= prod;
        rsp_id_q     <= gnt_idx;
        ptr_q        <= ptr_nxt;
      end
    end
  end

  assign bus.rsp_valid  = (st_q == StFull);
  assign bus.busy       = (st_q == StFull);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_fpmul_arb.sv
// Directed, table-driven bench for fpmul_arb with two requesters.
module tb_fpmul_arb;
  import lvg_fp_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fpmul_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fpmul_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [31:0]    exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[id*32 +: 32] = a;
    bus.req_b[id*32 +: 32] = b;
  endtask

  task automatic check_ready(input string name, input logic [1:0] exp);
    check(name, {30'b0, bus.req_ready}, {30'b0, exp});
  endtask

  task automatic check_rsp(input string name, input logic [IDW-1:0] id, input logic [31:0] res);
    check({name, " rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
    check({name, " busy"}, {31'b0, bus.busy}, 32'd1);
    check({name, " rsp_id"}, {31'b0, bus.rsp_id}, {31'b0, id});
    check({name, " rsp_result"}, bus.rsp_result, res);
  endtask

  task automatic check_empty(input string name);
    check({name, " rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    check({name, " busy"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{id: 1'd0, a: 32'h3f115b57, b: 32'h3fab851f, exp: 32'h3f42c732};
    vecs[1] = '{id: 1'd1, a: 32'h3f800000, b: 32'h40000000, exp: 32'h40000000};
    vecs[2] = '{id: 1'd0, a: 32'h3fc00000, b: 32'h3fc00000, exp: 32'h40100000};
    vecs[3] = '{id: 1'd1, a: 32'h40400000, b: 32'h40400000, exp: 32'h41100000};
    vecs[4] = '{id: 1'd0, a: 32'hc0000000, b: 32'h3f800000, exp: 32'hc0000000};
    vecs[5] = '{id: 1'd1, a: 32'h80000000, b: 32'h3f800000, exp: 32'h80000000};
    vecs[6] = '{id: 1'd0, a: 32'h3aa137f4, b: 32'h3c4985f0, exp: 32'h377dd28f};
    vecs[7] = '{id: 1'd1, a: 32'h7f800000, b: 32'h3f800000, exp: 32'h7f800000};

    // Reset with both requesters already asking.
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    set_lane(0, 32'h3f115b57, 32'h3fab851f);
    set_lane(1, FP_ONE, FP_ONE);
    repeat (2) @(posedge clk);
    #1;
    check_empty("reset");
    check("reset rsp_id", {31'b0, bus.rsp_id}, 32'd0);
    check("reset rsp_result", bus.rsp_result, 32'h0);
    check_ready("reset req_ready", 2'b00);

    rst_n = 1'b1;
    #1;
    check_ready("post-reset grant", 2'b01);
    tick();
    check_rsp("single req0", 1'd0, 32'h3f42c732);
    bus.req_valid = 2'b00;
    tick();
    check_empty("drain");

    // One product per cycle, single requester each cycle; last id 1 leaves ptr=0.
    for (int i = 0; i < 8; i++) begin
      set_lane(int'(vecs[i].id), vecs[i].a, vecs[i].b);
      bus.req_valid = 2'b01 << vecs[i].id;
      #1;
      check_ready($sformatf("vec%0d req_ready", i), 2'b01 << vecs[i].id);
      tick();
      check_rsp($sformatf("vec%0d", i), vecs[i].id, vecs[i].exp);
    end
    bus.req_valid = 2'b00;
    tick();
    check_empty("table drain");

    // Contention, ptr=0: grants alternate 0,1,0,1.
    set_lane(0, 32'h3aa137f4, 32'h3c4985f0);
    set_lane(1, FP_ONE, FP_ONE);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_ready($sformatf("contend%0d req_ready", k), (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check_rsp($sformatf("contend%0d", k), (k % 2 == 0) ? 1'd0 : 1'd1,
                (k % 2 == 0) ? 32'h377dd28f : FP_ONE);
    end

    // Backpressure while FULL with id 1: hold everything for 3 cycles.
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_ready($sformatf("stall%0d req_ready", c), 2'b00);
      check_rsp($sformatf("stall%0d", c), 1'd1, FP_ONE);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_ready("release req_ready", 2'b01);
    tick();
    check_rsp("release", 1'd0, 32'h377dd28f);
    bus.req_valid = 2'b00;
    #1;
    check_ready("release idle ready", 2'b00);
    tick();
    check_empty("release drain");

    // Zero operands back to back from requester 0.
    set_lane(0, 32'h00000000, 32'h3fab851f);
    bus.req_valid = 2'b01;
    #1;
    check_ready("zero1 req_ready", 2'b01);
    tick();
    check_rsp("zero1", 1'd0, 32'h00000000);
    set_lane(0, 32'h00000000, 32'h00000000);
    #1;
    check_ready("zero2 req_ready", 2'b01);
    tick();
    check_rsp("zero2", 1'd0, 32'h00000000);
    bus.req_valid = 2'b00;
    tick();

    // Idle 5 cycles with ptr=1; it must still favour requester 1 afterwards.
    for (int c = 0; c < 5; c++) begin
      check_ready($sformatf("idle%0d req_ready", c), 2'b00);
      check_empty($sformatf("idle%0d", c));
      tick();
    end
    set_lane(0, 32'h3f115b57, 32'h3fab851f);
    bus.req_valid = 2'b11;
    #1;
    check_ready("after idle req_ready", 2'b10);
    tick();
    check_rsp("after idle", 1'd1, FP_ONE);
    bus.req_valid = 2'b10;
    #1;
    check_ready("single req1 req_ready", 2'b10);
    tick();
    check_rsp("single req1", 1'd1, FP_ONE);
    bus.req_valid = 2'b00;
    tick();

    // Reset mid-transfer: FULL with id 0 and ptr=1, then asynchronous reset.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    check_ready("pre-reset req_ready", 2'b01);
    tick();
    check_rsp("pre-reset", 1'd0, 32'h3f42c732);
    #2;
    rst_n = 1'b0;
    #1;
    check_empty("mid reset");
    check("mid reset rsp_result", bus.rsp_result, 32'h0);
    check("mid reset rsp_id", {31'b0, bus.rsp_id}, 32'd0);
    check_ready("mid reset req_ready", 2'b00);
    #1;
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check_ready("re-release req_ready", 2'b01);
    tick();
    check_rsp("re-release", 1'd0, 32'h3f42c732);
    bus.req_valid = 2'b00;
    tick();
    check_empty("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
